mem_ctrl: RTL and testbench

Memory-side responder for the load/store buffer and the instruction fetcher. Accepts one-shot load/store requests (order, base, offset, store data) and fetch requests. Serialises them onto the 8-bit synchronous RAM/IO bus, one byte per cycle. Returns raw assembled data with a one-cycle ready pulse.

---
 rtl/mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the load/store buffer and the
// instruction fetcher. Serialises one request at a time onto the 8-bit
// synchronous RAM/IO bus, one byte per cycle, and returns raw little-endian
// assembled data with a one-cycle ready pulse.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state, forces mem_wr=0
//   clear               misprediction flush
//   lsb_load/lsb_store  one-shot request pulses with lsb_order/vj/A/vk
//   data_ready/data_ret lsb completion pulse and zero-extended raw result
//   if_req/if_pc        fetch request (level) and address
//   if_ready/if_inst    fetch completion pulse and fetched word
//   mem_din/mem_dout    RAM read / write byte
//   mem_a/mem_wr        RAM byte address / write strobe
//   io_buffer_full      IO write FIFO full
//
// Build option: define MEMCTRL_IO_STALL_EN to stall store bytes that target
// IO space (addr[17:16]==2'b11) while io_buffer_full is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | bus quiet, requests sampled here only
// S_LOAD  | cnt<n drives byte address cnt; cnt>=1 captures lane cnt-1
// S_STORE | cnt drives write of byte cnt; done after byte n-1
// S_FETCH | as S_LOAD, fixed 4 bytes, completes on if_ready

module mem_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic              lsb_load,
   input  logic              lsb_store,
   input  logic [5:0]        lsb_order,
   input  logic [31:0]       lsb_vj,
   input  logic [31:0]       lsb_A,
   input  logic [31:0]       lsb_vk,
   output logic              data_ready,
   output logic [31:0]       data_ret,
   input  logic              if_req,
   input  logic [31:0]       if_pc,
   output logic              if_ready,
   output logic [31:0]       if_inst,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   if (RAM_LAT != 1) begin : g_lat_check
      $error("mem_ctrl supports RAM_LAT == 1 only");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;

   state_t      state, state_nxt;
   logic [2:0]  cnt, cnt_nxt;
   logic [2:0]  n_r, n_nxt;
   logic [31:0] addr, addr_nxt;
   logic [31:0] wdata, wdata_nxt;
   logic [31:0] acc, acc_nxt;
   logic        suppress, suppress_nxt;
   logic        data_ready_nxt, if_ready_nxt;
   logic [31:0] data_ret_nxt, if_inst_nxt;

   logic [2:0]  req_n;
   logic        is_ld, is_st;
   logic        load_ok, store_ok;
   logic [2:0]  rd_idx;
   logic [31:0] byte_addr;
   logic [1:0]  lane;
   logic [31:0] merged;
   logic        stall;

   always_comb begin
      req_n = 3'd0;
      is_ld = 1'b0;
      is_st = 1'b0;
      case (lsb_order)
         6'd10, 6'd13: begin req_n = 3'd1; is_ld = 1'b1; end
         6'd11, 6'd14: begin req_n = 3'd2; is_ld = 1'b1; end
         6'd12:        begin req_n = 3'd4; is_ld = 1'b1; end
         6'd15:        begin req_n = 3'd1; is_st = 1'b1; end
         6'd16:        begin req_n = 3'd2; is_st = 1'b1; end
         6'd17:        begin req_n = 3'd4; is_st = 1'b1; end
         default:      ;
      endcase
   end

   assign load_ok  = lsb_load  && is_ld;
   assign store_ok = lsb_store && is_st;

   // While frozen in a read phase, point the RAM at the byte still waiting
   // to be captured so mem_din carries it again when rdy returns.
   assign rd_idx = (!rdy && cnt != 3'd0 && (state == S_LOAD || state == S_FETCH))
                   ? cnt - 3'd1 : cnt;
   assign byte_addr = addr + {29'd0, rd_idx};

   always_comb begin
      lane   = cnt[1:0] - 2'd1;
      merged = acc;
      merged[{lane, 3'b000} +: 8] = mem_din;
   end

`ifdef MEMCTRL_IO_STALL_EN
   assign stall = (byte_addr[17:16] == 2'b11) && io_buffer_full;
`else
   logic unused_io_full;
   assign unused_io_full = io_buffer_full;
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         n_r        <= 3'd0;
         addr       <= 32'd0;
         wdata      <= 32'd0;
         acc        <= 32'd0;
         suppress   <= 1'b0;
         data_ready <= 1'b0;
         data_ret   <= 32'd0;
         if_ready   <= 1'b0;
         if_inst    <= 32'd0;
      end else if (rdy) begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         n_r        <= n_nxt;
         addr       <= addr_nxt;
         wdata      <= wdata_nxt;
         acc        <= acc_nxt;
         suppress   <= suppress_nxt;
         data_ready <= data_ready_nxt;
         data_ret   <= data_ret_nxt;
         if_ready   <= if_ready_nxt;
         if_inst    <= if_inst_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      n_nxt          = n_r;
      addr_nxt       = addr;
      wdata_nxt      = wdata;
      acc_nxt        = acc;
      suppress_nxt   = suppress;
      data_ready_nxt = 1'b0;
      if_ready_nxt   = 1'b0;
      data_ret_nxt   = data_ret;
      if_inst_nxt    = if_inst;
      mem_a          = '0;
      mem_dout       = 8'd0;
      mem_wr         = 1'b0;

      case (state)
         S_IDLE: begin
            if (!clear) begin
               if (load_ok || store_ok) begin
                  state_nxt    = load_ok ? S_LOAD : S_STORE;
                  addr_nxt     = lsb_vj + lsb_A;
                  n_nxt        = req_n;
                  cnt_nxt      = 3'd0;
                  acc_nxt      = 32'd0;
                  wdata_nxt    = lsb_vk;
                  suppress_nxt = 1'b0;
               end else if (if_req) begin
                  state_nxt = S_FETCH;
                  addr_nxt  = if_pc;
                  n_nxt     = 3'd4;
                  cnt_nxt   = 3'd0;
                  acc_nxt   = 32'd0;
               end
            end
         end

         S_LOAD, S_FETCH: begin
            mem_a = byte_addr[ADDR_W-1:0];
            if (clear) begin
               state_nxt = S_IDLE;
            end else begin
               if (cnt != 3'd0) acc_nxt = merged;
               if (cnt == n_r) begin
                  state_nxt = S_IDLE;
                  if (state == S_LOAD) begin
                     data_ready_nxt = 1'b1;
                     data_ret_nxt   = merged;
                  end else begin
                     if_ready_nxt = 1'b1;
                     if_inst_nxt  = merged;
                  end
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end

         S_STORE: begin
            mem_a    = byte_addr[ADDR_W-1:0];
            mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = rdy && !stall;
            // A committed store cannot be cancelled; only its pulse is dropped.
            if (clear) suppress_nxt = 1'b1;
            if (!stall) begin
               if (cnt == n_r - 3'd1) begin
                  state_nxt = S_IDLE;
                  if (!(suppress || clear)) begin
                     data_ready_nxt = 1'b1;
                     data_ret_nxt   = 32'd0;
                  end
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected ready
// pulses, bus writes and read addresses into queues; monitors sampling on
// the falling edge pop and compare whenever the DUT presents them.

module tb_mem_ctrl;

   logic        clk, rst, rdy, clear;
   logic        lsb_load, lsb_store;
   logic [5:0]  lsb_order;
   logic [31:0] lsb_vj, lsb_A, lsb_vk;
   logic        data_ready, if_ready, if_req;
   logic [31:0] data_ret, if_inst, if_pc;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full;

   mem_ctrl #(.ADDR_W(32), .RAM_LAT(1)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .lsb_load(lsb_load), .lsb_store(lsb_store), .lsb_order(lsb_order),
      .lsb_vj(lsb_vj), .lsb_A(lsb_A), .lsb_vk(lsb_vk),
      .data_ready(data_ready), .data_ret(data_ret),
      .if_req(if_req), .if_pc(if_pc), .if_ready(if_ready), .if_inst(if_inst),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   typedef struct {
      int          cyc;
      logic [31:0] v;
   } exp_t;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   exp_t dq[$];
   exp_t fq[$];
   exp_t bq[$];
   wr_t  wq[$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0;

   logic [7:0] ram [0:65535];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) ram[mem_a[15:0]] = mem_dout;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic lsb_req(input logic ld, input logic [5:0] ord,
                          input logic [31:0] vj, input logic [31:0] a,
                          input logic [31:0] vk);
      lsb_load  = ld;
      lsb_store = !ld;
      lsb_order = ord;
      lsb_vj    = vj;
      lsb_A     = a;
      lsb_vk    = vk;
   endtask

   task automatic lsb_drop();
      lsb_load  = 1'b0;
      lsb_store = 1'b0;
   endtask

   // Monitors
   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      if (!rst) begin
         if (data_ready) begin
            if (dq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_data_ready data_ret=0x%08h (cycle %0d)", data_ret, cyc);
            end else begin
               e = dq.pop_front();
               check("data_ready_cycle", cyc, e.cyc);
               check("data_ret", data_ret, e.v);
            end
         end
         if (if_ready) begin
            if (fq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_if_ready if_inst=0x%08h (cycle %0d)", if_inst, cyc);
            end else begin
               e = fq.pop_front();
               check("if_ready_cycle", cyc, e.cyc);
               check("if_inst", if_inst, e.v);
            end
         end
         if (mem_wr) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write a=0x%08h d=0x%02h (cycle %0d)", mem_a, mem_dout, cyc);
            end else begin
               w = wq.pop_front();
               check("write_cycle", cyc, w.cyc);
               check("write_addr", mem_a, w.a);
               check("write_data", {24'd0, mem_dout}, {24'd0, w.d});
            end
         end
         while (bq.size() > 0 && bq[0].cyc == cyc) begin
            e = bq.pop_front();
            check("bus_addr", mem_a, e.v);
         end
      end
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; clear = 1'b0;
      lsb_load = 1'b0; lsb_store = 1'b0; lsb_order = 6'd0;
      lsb_vj = 32'd0; lsb_A = 32'd0; lsb_vk = 32'd0;
      if_req = 1'b0; if_pc = 32'd0; io_buffer_full = 1'b0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      ram[16'h0104] = 8'h11; ram[16'h0105] = 8'h22;
      ram[16'h0106] = 8'h33; ram[16'h0107] = 8'h44;
      ram[16'h0000] = 8'h13; ram[16'h0001] = 8'h05;
      ram[16'h0002] = 8'h00; ram[16'h0003] = 8'h00;

      step(3);
      rst = 1'b0;
      @(negedge clk);
      check("reset_data_ready", {31'd0, data_ready}, 32'd0);
      check("reset_data_ret", data_ret, 32'd0);
      check("reset_if_ready", {31'd0, if_ready}, 32'd0);
      check("reset_if_inst", if_inst, 32'd0);
      check("reset_mem_a", mem_a, 32'd0);
      check("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
      check("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
      step(2);

      // LW 0x100+4
      t0 = cyc;
      lsb_req(1'b1, 6'd12, 32'h100, 32'h4, 32'h0);
      bq.push_back('{t0 + 1, 32'h104});
      bq.push_back('{t0 + 2, 32'h105});
      bq.push_back('{t0 + 3, 32'h106});
      bq.push_back('{t0 + 4, 32'h107});
      dq.push_back('{t0 + 6, 32'h44332211});
      step(1); lsb_drop();
      step(8);

      // SH 0x1FF+1, carry into next page
      t0 = cyc;
      lsb_req(1'b0, 6'd16, 32'h1FF, 32'h1, 32'hDEADBEEF);
      wq.push_back('{t0 + 1, 32'h200, 8'hEF});
      wq.push_back('{t0 + 2, 32'h201, 8'hBE});
      dq.push_back('{t0 + 3, 32'h0});
      step(1); lsb_drop();
      step(5);

      // LB of the byte just stored: raw, zero-extended
      t0 = cyc;
      lsb_req(1'b1, 6'd10, 32'h200, 32'h0, 32'h0);
      bq.push_back('{t0 + 1, 32'h200});
      dq.push_back('{t0 + 3, 32'h000000EF});
      step(1); lsb_drop();
      step(5);

      // LHU 0x100+6
      t0 = cyc;
      lsb_req(1'b1, 6'd14, 32'h100, 32'h6, 32'h0);
      dq.push_back('{t0 + 4, 32'h00004433});
      step(1); lsb_drop();
      step(5);

      // LW and fetch together: load first, fetch restarts when load finishes
      t0 = cyc;
      lsb_req(1'b1, 6'd12, 32'h100, 32'h4, 32'h0);
      if_req = 1'b1; if_pc = 32'h0;
      dq.push_back('{t0 + 6, 32'h44332211});
      bq.push_back('{t0 + 7, 32'h0});
      bq.push_back('{t0 + 8, 32'h1});
      bq.push_back('{t0 + 9, 32'h2});
      bq.push_back('{t0 + 10, 32'h3});
      fq.push_back('{t0 + 12, 32'h00000513});
      step(1); lsb_drop();
      step(11); if_req = 1'b0;
      step(5);

      // clear in cycle 2 of LW: aborted, idle in cycle 3
      t0 = cyc;
      lsb_req(1'b1, 6'd12, 32'h100, 32'h4, 32'h0);
      bq.push_back('{t0 + 3, 32'h0});
      bq.push_back('{t0 + 4, 32'h0});
      step(1); lsb_drop();
      step(1); clear = 1'b1;
      step(1); clear = 1'b0;
      step(6);

      // clear in cycle 2 of SW: all bytes written, no pulse
      t0 = cyc;
      lsb_req(1'b0, 6'd17, 32'h300, 32'h0, 32'h01020304);
      wq.push_back('{t0 + 1, 32'h300, 8'h04});
      wq.push_back('{t0 + 2, 32'h301, 8'h03});
      wq.push_back('{t0 + 3, 32'h302, 8'h02});
      wq.push_back('{t0 + 4, 32'h303, 8'h01});
      step(1); lsb_drop();
      step(1); clear = 1'b1;
      step(1); clear = 1'b0;
      step(6);

      // read back the flushed store
      t0 = cyc;
      lsb_req(1'b1, 6'd12, 32'h2FF, 32'h1, 32'h0);
      dq.push_back('{t0 + 6, 32'h01020304});
      step(1); lsb_drop();
      step(8);

      // unknown order code: ignored
      t0 = cyc;
      lsb_req(1'b1, 6'd5, 32'h100, 32'h4, 32'h0);
      bq.push_back('{t0 + 1, 32'h0});
      bq.push_back('{t0 + 2, 32'h0});
      step(1); lsb_drop();
      step(5);

      // rdy low for cycles 3-4 of LW: stretched by 2, data intact
      t0 = cyc;
      lsb_req(1'b1, 6'd12, 32'h100, 32'h4, 32'h0);
      dq.push_back('{t0 + 8, 32'h44332211});
      step(1); lsb_drop();
      step(2); rdy = 1'b0;
      step(2); rdy = 1'b1;
      step(8);

      // SB to IO space with io_buffer_full in cycles 1-2
      t0 = cyc;
      lsb_req(1'b0, 6'd15, 32'h30000, 32'h0, 32'h0000005A);
`ifdef MEMCTRL_IO_STALL_EN
      wq.push_back('{t0 + 3, 32'h30000, 8'h5A});
      dq.push_back('{t0 + 4, 32'h0});
`else
      wq.push_back('{t0 + 1, 32'h30000, 8'h5A});
      dq.push_back('{t0 + 2, 32'h0});
`endif
      step(1); lsb_drop(); io_buffer_full = 1'b1;
      step(2); io_buffer_full = 1'b0;
      step(6);

      // rst in cycle 3 of a fetch: all outputs 0 from cycle 4, no if_ready
      t0 = cyc;
      if_req = 1'b1; if_pc = 32'h10;
      step(3); rst = 1'b1; if_req = 1'b0;
      step(1); rst = 1'b0;
      @(negedge clk);
      check("rst_cyc", cyc, t0 + 4);
      check("rst_data_ready", {31'd0, data_ready}, 32'd0);
      check("rst_data_ret", data_ret, 32'd0);
      check("rst_if_ready", {31'd0, if_ready}, 32'd0);
      check("rst_if_inst", if_inst, 32'd0);
      check("rst_mem_a", mem_a, 32'd0);
      check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      step(20);

      check("dq_left", dq.size(), 32'd0);
      check("fq_left", fq.size(), 32'd0);
      check("wq_left", wq.size(), 32'd0);
      check("bq_left", bq.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
